// File: rtl/marquee_pkg.sv
// -----------------------------------------------------------------------------
// marquee_pkg
// Shared definitions for the scrolling marquee block.
//   CODE_W     : bits per character code carried on msg_i / win_o
//   CH_*       : character codes understood by the downstream letter decoder
//   wrap_add() : modular addition for index arithmetic on any MSG_LEN
// -----------------------------------------------------------------------------
package marquee_pkg;

   localparam int CODE_W = 3;

   localparam logic [CODE_W-1:0] CH_H     = 3'd0;
   localparam logic [CODE_W-1:0] CH_E     = 3'd1;
   localparam logic [CODE_W-1:0] CH_L     = 3'd2;
   localparam logic [CODE_W-1:0] CH_O     = 3'd3;
   localparam logic [CODE_W-1:0] CH_BLANK = 3'd7;

   // Both operands are already reduced (a, b < m), so one conditional
   // subtraction gives (a + b) mod m without a divider.
   function automatic int wrap_add(input int a, input int b, input int m);
      int s;
      s = a + b;
      if (s >= m)
         s = s - m;
      return s;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the input clock down to the scroll tick rate. The terminal count is
// (DIV >> speed) - 1, floored at 0, so each speed step doubles the rate.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   en    : count only while high; the count is held while low
//   speed : 2-bit rate multiplier (2^speed)
//   clr   : synchronous clear of the count (message load)
//   tick  : one-cycle pulse when the count reaches the terminal count
// -----------------------------------------------------------------------------
module tick_prescaler
   import marquee_pkg::*;
#(
   parameter int DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] speed,
   input  logic       clr,
   output logic       tick
);

   // Largest terminal count is DIV-1, which always fits in $clog2(DIV) bits.
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] term;
   int               t_int;

   always_comb begin
      t_int = (DIV >> speed) - 1;
      if (t_int < 0)
         t_int = 0;
      term = CNT_W'(t_int);
   end

   // ">=" rather than "==": dropping to a faster speed can leave the count
   // above the new terminal value, and that must tick at once, not roll over.
   assign tick = en && (cnt_q >= term);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (clr)
         cnt_q <= '0;
      else if (en) begin
         if (cnt_q >= term)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/scroll_marquee.sv
// -----------------------------------------------------------------------------
// scroll_marquee
// Scrolls a captured message through an N_DIGITS-wide display window, either
// automatically at a prescaled rate or by manual step pulses.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-high reset
//   en     : auto-scroll enable (step is ignored while high)
//   dir    : 0 = scroll left (index up), 1 = scroll right (index down)
//   speed  : rate multiplier 2^speed
//   step   : single-cycle manual advance, honoured only while en = 0
//   load   : single-cycle capture of msg_i; resets index and prescaler
//   msg_i  : message, char c at [c*CODE_W +: CODE_W]
//   win_o  : window codes, slot 0 is the rightmost digit
//   pos_o  : index of the leftmost displayed character
//   wrap_o : one-cycle pulse when the index wraps
// -----------------------------------------------------------------------------
module scroll_marquee
   import marquee_pkg::*;
#(
   parameter int CLK_HZ   = 50_000_000,
   parameter int TICK_HZ  = 1,
   parameter int MSG_LEN  = 8,
   parameter int N_DIGITS = 6,
   parameter int CODE_W   = marquee_pkg::CODE_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         dir,
   input  logic [1:0]                   speed,
   input  logic                         step,
   input  logic                         load,
   input  logic [MSG_LEN*CODE_W-1:0]    msg_i,
   output logic [N_DIGITS*CODE_W-1:0]   win_o,
   output logic [$clog2(MSG_LEN)-1:0]   pos_o,
   output logic                         wrap_o
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int IDX_W = $clog2(MSG_LEN);
   localparam int MSG_W = MSG_LEN * CODE_W;
   localparam int WIN_W = N_DIGITS * CODE_W;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

   logic             tick;
   logic             adv;
   logic             wrap_nx;
   logic [IDX_W-1:0] idx_nx;
   logic [MSG_W-1:0] msg_buf_q;
   logic [MSG_W-1:0] msg_buf_nx;
   logic [WIN_W-1:0] win_nx;
   int               k;

   tick_prescaler #(
      .DIV (DIV)
   ) u_presc (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .speed (speed),
      .clr   (load),
      .tick  (tick)
   );

   // Auto-scroll owns the index while enabled; manual steps only when paused.
   assign adv = en ? tick : step;

   always_comb begin
      msg_buf_nx = msg_buf_q;
      idx_nx     = pos_o;
      wrap_nx    = 1'b0;
      if (load) begin
         msg_buf_nx = msg_i;
         idx_nx     = '0;
      end else if (adv) begin
         if (!dir) begin
            if (pos_o == IDX_LAST) begin
               idx_nx  = '0;
               wrap_nx = 1'b1;
            end else begin
               idx_nx = pos_o + IDX_W'(1);
            end
         end else begin
            if (pos_o == '0) begin
               idx_nx  = IDX_LAST;
               wrap_nx = 1'b1;
            end else begin
               idx_nx = pos_o - IDX_W'(1);
            end
         end
      end
   end

   // Window is built from the next-state buffer and index so that win_o,
   // pos_o and wrap_o all change on the same edge.
   always_comb begin
      win_nx = '0;
      k      = 0;
      for (int j = 0; j < N_DIGITS; j++) begin
         k = wrap_add(int'(idx_nx), N_DIGITS - 1 - j, MSG_LEN);
         win_nx[j*CODE_W +: CODE_W] = msg_buf_nx[k*CODE_W +: CODE_W];
      end
   end

   // Output register stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msg_buf_q <= '0;
         pos_o     <= '0;
         win_o     <= '0;
         wrap_o    <= 1'b0;
      end else begin
         msg_buf_q <= msg_buf_nx;
         pos_o     <= idx_nx;
         win_o     <= win_nx;
         wrap_o    <= wrap_nx;
      end
   end

endmodule

// File: tb/tb_scroll_marquee.sv
// -----------------------------------------------------------------------------
// tb_scroll_marquee
// Directed bench for scroll_marquee with CLK_HZ=4, TICK_HZ=1 (DIV=4),
// MSG_LEN=8, N_DIGITS=6, CODE_W=3.
// -----------------------------------------------------------------------------
module tb_scroll_marquee;
   import marquee_pkg::*;

   localparam int ML = 8;
   localparam int ND = 6;
   localparam int CW = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             dir;
   logic [1:0]       speed;
   logic             step;
   logic             load;
   logic [ML*CW-1:0] msg_i;
   logic [ND*CW-1:0] win_o;
   logic [2:0]       pos_o;
   logic             wrap_o;

   int total = 0;
   int bad   = 0;

   logic [ML*CW-1:0] hello;
   logic [ML*CW-1:0] m2;
   logic [CW-1:0]    hello_ch [ML];

   scroll_marquee #(
      .CLK_HZ   (4),
      .TICK_HZ  (1),
      .MSG_LEN  (ML),
      .N_DIGITS (ND),
      .CODE_W   (CW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .dir    (dir),
      .speed  (speed),
      .step   (step),
      .load   (load),
      .msg_i  (msg_i),
      .win_o  (win_o),
      .pos_o  (pos_o),
      .wrap_o (wrap_o)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ND*CW-1:0] exp_win(input logic [ML*CW-1:0] m, input int idx);
      logic [ND*CW-1:0] r;
      r = '0;
      for (int j = 0; j < ND; j++)
         r[j*CW +: CW] = m[((idx + ND - 1 - j) % ML)*CW +: CW];
      return r;
   endfunction

   initial begin
      hello = {CH_BLANK, CH_BLANK, CH_BLANK, CH_O, CH_L, CH_L, CH_E, CH_H};
      m2    = {CH_O, CH_L, CH_E, CH_H, CH_O, CH_L, CH_E, CH_H};
      hello_ch = '{CH_H, CH_E, CH_L, CH_L, CH_O, CH_BLANK, CH_BLANK, CH_BLANK};

      rst = 1'b1; en = 1'b0; dir = 1'b0; speed = 2'd0;
      step = 1'b0; load = 1'b0; msg_i = hello;
      cyc(2);
      check("rst_pos",  32'(pos_o),  32'd0);
      check("rst_win",  32'(win_o),  32'd0);
      check("rst_wrap", 32'(wrap_o), 32'd0);

      // capture HELLO
      rst = 1'b0; load = 1'b1;
      cyc(1);
      load = 1'b0;
      check("load_pos",  32'(pos_o),  32'd0);
      check("load_win",  32'(win_o),  32'(18'b000_001_010_010_011_111));
      check("load_wrap", 32'(wrap_o), 32'd0);

      // auto scroll left, one advance per 4 cycles
      en = 1'b1;
      for (int i = 1; i < ML; i++) begin
         cyc(3);
         check("hold_pos", 32'(pos_o), 32'(i - 1));
         cyc(1);
         check("adv_pos",   32'(pos_o),        32'(i));
         check("adv_slot5", 32'(win_o[17:15]), 32'(hello_ch[i]));
         check("adv_win",   32'(win_o),        32'(exp_win(hello, i)));
         check("adv_wrap",  32'(wrap_o),       32'd0);
      end

      // left wrap 7 -> 0
      cyc(3);
      check("prewrap_pos",  32'(pos_o),  32'd7);
      check("prewrap_wrap", 32'(wrap_o), 32'd0);
      cyc(1);
      check("wrapL_pos",  32'(pos_o),  32'd0);
      check("wrapL_wrap", 32'(wrap_o), 32'd1);
      check("wrapL_win",  32'(win_o),  32'(exp_win(hello, 0)));

      // right wrap 0 -> 7
      dir = 1'b1;
      cyc(1);
      check("wrapL_once", 32'(wrap_o), 32'd0);
      cyc(2);
      check("wrapR_hold", 32'(pos_o), 32'd0);
      cyc(1);
      check("wrapR_pos",  32'(pos_o),  32'd7);
      check("wrapR_wrap", 32'(wrap_o), 32'd1);
      check("wrapR_win",  32'(win_o),  32'(exp_win(hello, 7)));
      cyc(1);
      check("wrapR_once", 32'(wrap_o), 32'd0);
      check("wrapR_keep", 32'(pos_o),  32'd7);

      // manual steps while paused: 7 -> 0 -> 1 -> 2
      en = 1'b0; dir = 1'b0;
      for (int s = 0; s < 3; s++) begin
         step = 1'b1;
         cyc(1);
         step = 1'b0;
         check("step_pos",  32'(pos_o),  32'(s));
         check("step_wrap", 32'(wrap_o), (s == 0) ? 32'd1 : 32'd0);
         cyc(1);
      end
      cyc(5);
      check("paused_pos", 32'(pos_o), 32'd2);

      // step with en=1 is ignored (prescaler count goes 1 -> 2)
      en = 1'b1; step = 1'b1;
      cyc(1);
      step = 1'b0;
      check("step_en_ign", 32'(pos_o), 32'd2);

      // speed 0 -> 3 with count 2: tick next cycle, then every cycle
      speed = 2'd3;
      cyc(1);
      check("fast_pos1", 32'(pos_o), 32'd3);
      cyc(1);
      check("fast_pos2", 32'(pos_o), 32'd4);

      // load coincident with a tick at pos 4
      msg_i = m2; load = 1'b1;
      cyc(1);
      load = 1'b0;
      check("ldtick_pos",  32'(pos_o),  32'd0);
      check("ldtick_wrap", 32'(wrap_o), 32'd0);
      check("ldtick_win",  32'(win_o),  32'(exp_win(m2, 0)));

      // msg_i change without load is invisible
      speed = 2'd0; msg_i = hello;
      cyc(1);
      check("noload_win", 32'(win_o), 32'(exp_win(m2, 0)));
      cyc(19);
      check("mid_pos", 32'(pos_o), 32'd5);
      check("mid_win", 32'(win_o), 32'(exp_win(m2, 5)));

      // asynchronous reset mid-scroll
      cyc(2);
      #2 rst = 1'b1;
      #1;
      check("arst_pos",  32'(pos_o),  32'd0);
      check("arst_win",  32'(win_o),  32'd0);
      check("arst_wrap", 32'(wrap_o), 32'd0);
      cyc(1);
      rst = 1'b0;
      cyc(3);
      check("postrst_hold", 32'(pos_o), 32'd0);
      cyc(1);
      check("postrst_pos", 32'(pos_o), 32'd1);
      check("postrst_win", 32'(win_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
